// File: rtl/div_pkg.sv
// div_pkg: shared widths, FSM encodings and handshake constants for the divider
//   RegBus / DoubleRegBus : operand and result widths
//   div_state_e           : DivFree, DivByZero, DivOn, DivEnd
//   DivStart / DivStop, DivResultReady / DivResultNotReady, RstEnable
//   mag()                 : two's-complement magnitude when signed and negative
package div_pkg;
   localparam int RegBus       = 32;
   localparam int DoubleRegBus = 64;
   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;
   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;
   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic RstEnable         = 1'b1;
   function automatic logic [RegBus-1:0] mag(input logic s, input logic [RegBus-1:0] v);
      return (s && v[RegBus-1]) ? -v : v;
   endfunction
endpackage

// File: rtl/div.sv
// div: 32-step restoring divider (signed/unsigned) with start/annul handshake
//   clk, rst       : rising-edge clock, synchronous active-high reset
//   signed_div_i   : 1 = signed, 0 = unsigned
//   opdata1_i/2_i  : dividend / divisor, latched on the first start cycle
//   start_i        : request, held high until ready_o is seen
//   annul_i        : abandon the current operation
//   result_o       : {remainder, quotient}, non-zero only while ready_o
//   ready_o        : result valid
// Optional: define DIV_BYZERO_EN to short-cut a zero divisor to a zero result.
module div
   import div_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    signed_div_i,
   input  logic [RegBus-1:0]       opdata1_i,
   input  logic [RegBus-1:0]       opdata2_i,
   input  logic                    start_i,
   input  logic                    annul_i,
   output logic [DoubleRegBus-1:0] result_o,
   output logic                    ready_o
);
   div_state_e              state_q, state_d;
   logic [5:0]              cnt_q, cnt_d;
   logic [RegBus-1:0]       rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic                    qneg_q, qneg_d, rneg_q, rneg_d;
   logic                    ready_q, ready_d;
   logic [DoubleRegBus-1:0] result_q, result_d;
   logic [RegBus:0]         shifted, trial;
   logic                    ge;
   logic [RegBus-1:0]       rem_nx, quo_nx;
   // Quotient register starts as the dividend and shifts out its MSB into the
   // partial remainder while quotient bits shift in from the bottom.
   assign shifted = {rem_q, quo_q[RegBus-1]};
   assign trial   = shifted - {1'b0, dvs_q};
   // A set top bit in the shifted remainder already exceeds any divisor.
   assign ge      = shifted[RegBus] | ~trial[RegBus];
   assign rem_nx  = ge ? trial[RegBus-1:0] : shifted[RegBus-1:0];
   assign quo_nx  = {quo_q[RegBus-2:0], ge};
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      ready_d  = ready_q;
      result_d = result_q;
      case (state_q)
         DivFree: begin
            if (start_i == DivStart && !annul_i) begin
               rem_d   = '0;
               quo_d   = mag(signed_div_i, opdata1_i);
               dvs_d   = mag(signed_div_i, opdata2_i);
               qneg_d  = signed_div_i & (opdata1_i[RegBus-1] ^ opdata2_i[RegBus-1]);
               rneg_d  = signed_div_i & opdata1_i[RegBus-1];
               cnt_d   = '0;
`ifdef DIV_BYZERO_EN
               state_d = (opdata2_i == '0) ? DivByZero : DivOn;
`else
               state_d = DivOn;
`endif
            end
         end
`ifdef DIV_BYZERO_EN
         DivByZero: begin
            state_d  = annul_i ? DivFree : DivEnd;
            ready_d  = annul_i ? DivResultNotReady : DivResultReady;
            result_d = '0;
         end
`endif
         DivOn: begin
            if (annul_i) begin
               state_d = DivFree;
            end else begin
               rem_d = rem_nx;
               quo_d = quo_nx;
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'd31) begin
                  state_d  = DivEnd;
                  ready_d  = DivResultReady;
                  result_d = {rneg_q ? -rem_nx : rem_nx, qneg_q ? -quo_nx : quo_nx};
               end
            end
         end
         DivEnd: begin
            if (annul_i || start_i == DivStop) begin
               state_d  = DivFree;
               ready_d  = DivResultNotReady;
               result_d = '0;
            end
         end
         default: state_d = DivFree;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         state_q  <= DivFree;
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         ready_q  <= DivResultNotReady;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         ready_q  <= ready_d;
         result_q <= result_d;
      end
   end
   assign ready_o  = ready_q;
   assign result_o = result_q;
endmodule

// File: tb/tb_div.sv
// tb_div: randomized and directed self-checking bench for div against a behavioural model
module tb_div;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        signed_div_i = 1'b0;
   logic [31:0] opdata1_i = '0;
   logic [31:0] opdata2_i = '0;
   logic        start_i = 1'b0;
   logic        annul_i = 1'b0;
   logic [63:0] result_o;
   logic        ready_o;
   int          pass_cnt = 0;
   int          total_cnt = 0;
`ifdef DIV_BYZERO_EN
   localparam bit BYZ = 1'b1;
`else
   localparam bit BYZ = 1'b0;
`endif
   div dut (
      .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
      .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
      .start_i(start_i), .annul_i(annul_i),
      .result_o(result_o), .ready_o(ready_o)
   );
   always #5 clk = ~clk;
   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
      logic [31:0] ua, ub, q, r;
      ua = (s && a[31]) ? -a : a;
      ub = (s && b[31]) ? -b : b;
      if (ub == 0) begin
         q = '1;
         r = ua;
      end else begin
         q = ua / ub;
         r = ua % ub;
      end
      if (s && (a[31] ^ b[31])) q = -q;
      if (s && a[31]) r = -r;
      return {r, q};
   endfunction
   function automatic logic [63:0] exp_res(input logic [31:0] a, input logic [31:0] b, input logic s);
      return (BYZ && b == 0) ? 64'h0 : ref_div(a, b, s);
   endfunction
   function automatic int exp_lat(input logic [31:0] b);
      return (BYZ && b == 0) ? 2 : 33;
   endfunction
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask
   // Behavioural model: idle / busy for a fixed number of edges / done.
   int          m_mode = 0;
   int          m_left = 0;
   logic [63:0] m_res = '0;
   logic        exp_ready = 1'b0;
   logic [63:0] exp_result = '0;
   always @(posedge clk) begin
      if (rst) begin
         m_mode <= 0;
         exp_ready <= 1'b0;
         exp_result <= '0;
      end else if (m_mode == 0) begin
         if (start_i && !annul_i) begin
            m_mode <= 1;
            m_left <= exp_lat(opdata2_i) - 1;
            m_res  <= exp_res(opdata1_i, opdata2_i, signed_div_i);
         end
      end else if (m_mode == 1) begin
         if (annul_i) m_mode <= 0;
         else if (m_left == 1) begin
            m_mode <= 2;
            exp_ready <= 1'b1;
            exp_result <= m_res;
         end else m_left <= m_left - 1;
      end else if (annul_i || !start_i) begin
         m_mode <= 0;
         exp_ready <= 1'b0;
         exp_result <= '0;
      end
   end
   always @(posedge clk) begin
      #1;
      chk("cyc_ready", {63'b0, ready_o}, {63'b0, exp_ready});
      chk("cyc_result", result_o, exp_result);
   end
   task automatic wait_ready(input int lat, input logic [63:0] res, input string name, input bit scramble);
      int n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (!ready_o && scramble) begin
            @(negedge clk);
            opdata1_i = $urandom;
            opdata2_i = $urandom;
            signed_div_i = 1'($urandom_range(0, 1));
         end
      end while (!ready_o && n < 60);
      chk({name, "_lat"}, 64'(n), 64'(lat));
      chk({name, "_res"}, result_o, res);
   endtask
   task automatic end_op(input int hold, input logic [63:0] res, input string name);
      repeat (hold) begin
         @(posedge clk);
         #1;
         chk({name, "_hold"}, {ready_o, result_o[62:0]}, {1'b1, res[62:0]});
      end
      @(negedge clk);
      start_i = 1'b0;
      @(posedge clk);
      #1;
      chk({name, "_drop"}, {63'b0, ready_o} | result_o, 64'h0);
      @(negedge clk);
   endtask
   task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
      @(negedge clk);
      opdata1_i = a;
      opdata2_i = b;
      signed_div_i = s;
      start_i = 1'b1;
   endtask
   initial begin
      logic [31:0] a, b;
      logic        s;
      chk("pin_u", ref_div(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
      chk("pin_s", ref_div(32'hFFFFFFF9, 32'd2, 1'b1), {32'hFFFFFFFF, 32'hFFFFFFFD});
      chk("pin_wrap", ref_div(32'h80000000, 32'hFFFFFFFF, 1'b1), {32'h0, 32'h80000000});
      chk("pin_zero", ref_div(32'd5, 32'd0, 1'b0), {32'd5, 32'hFFFFFFFF});
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", {63'b0, ready_o} | result_o, 64'h0);
      @(negedge clk);
      rst = 1'b0;
      launch(32'd100, 32'd7, 1'b0);
      wait_ready(33, {32'd2, 32'd14}, "u100_7", 1'b0);
      end_op(5, {32'd2, 32'd14}, "u100_7");
      launch(32'hFFFFFFF9, 32'd2, 1'b1);
      wait_ready(33, {32'hFFFFFFFF, 32'hFFFFFFFD}, "s_m7_2", 1'b0);
      end_op(1, {32'hFFFFFFFF, 32'hFFFFFFFD}, "s_m7_2");
      launch(32'h80000000, 32'hFFFFFFFF, 1'b1);
      wait_ready(33, {32'h0, 32'h80000000}, "s_wrap", 1'b0);
      end_op(0, {32'h0, 32'h80000000}, "s_wrap");
      launch(32'd5, 32'd0, 1'b0);
      if (BYZ) wait_ready(2, 64'h0, "u5_0", 1'b0);
      else wait_ready(33, {32'd5, 32'hFFFFFFFF}, "u5_0", 1'b0);
      end_op(1, BYZ ? 64'h0 : {32'd5, 32'hFFFFFFFF}, "u5_0");
      // Annul in cycle 10 with start still held: restart at cycle 11.
      launch(32'd100, 32'd7, 1'b0);
      repeat (10) @(posedge clk);
      @(negedge clk);
      annul_i = 1'b1;
      @(posedge clk);
      #1;
      chk("annul_ready", {63'b0, ready_o}, 64'h0);
      @(negedge clk);
      annul_i = 1'b0;
      wait_ready(33, {32'd2, 32'd14}, "annul_restart", 1'b0);
      end_op(0, {32'd2, 32'd14}, "annul_restart");
      // Reset in cycle 20 with start still held: restart after reset.
      launch(32'd100, 32'd7, 1'b0);
      repeat (20) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid", {63'b0, ready_o} | result_o, 64'h0);
      @(negedge clk);
      rst = 1'b0;
      wait_ready(33, {32'd2, 32'd14}, "rst_restart", 1'b0);
      end_op(0, {32'd2, 32'd14}, "rst_restart");
      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         b = $urandom;
         s = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0: b = 0;
            1: b = $urandom_range(1, 9);
            2: a = $urandom_range(0, 100);
            3: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            default: ;
         endcase
         launch(a, b, s);
         wait_ready(exp_lat(b), exp_res(a, b, s), "rand", 1'b1);
         end_op($urandom_range(0, 3), exp_res(a, b, s), "rand");
      end
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 The block SHALL have no parameters; widths SHALL come from the shared defines (`RegBus` = 32, `DoubleRegBus` = 64).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 `clk`  input  1  rising-edge clock.
REQ-004 `rst`  input  1  synchronous reset, active-high (`RstEnable`).
REQ-005 `signed_div_i`  input  1  1 = signed divide (div), 0 = unsigned (divu).
REQ-006 `opdata1_i`  input  32  dividend.
REQ-007 `opdata2_i`  input  32  divisor.
REQ-008 `start_i`  input  1  request; EX holds it high (`DivStart`) until it sees ready.
REQ-009 `annul_i`  input  1  cancel the current operation (flush); tied 0 until the flush logic exists.
REQ-010 `result_o`  output  64  {remainder[63:32], quotient[31:0]}; EX writes it into {hi, lo}.
REQ-011 `ready_o`  output  1  result valid (`DivResultReady`).

Function
REQ-012 The FSM SHALL have the states DivFree, DivByZero, DivOn and DivEnd, with encodings defined in the shared defines.
REQ-013 DivFree: if start_i=1 and annul_i=0, latch the operands and go to DivOn; with DIV_BYZERO_EN defined and opdata2_i=0, go to DivByZero instead; otherwise stay in DivFree.
REQ-014 On latch in signed mode, each negative operand SHALL be replaced by its two's-complement magnitude; unsigned operands SHALL be used as-is.
REQ-015 DivOn SHALL perform one restoring step per cycle:
- 33-bit trial = partial_remainder minus {0, divisor}.
- Negative trial: shift in quotient bit 0.
- Otherwise: keep the difference as the new partial remainder and shift in quotient bit 1.
- 6-bit counter runs 0..31.
REQ-016 After the 32nd step the FSM SHALL go to DivEnd.
REQ-017 Sign fix on entering DivEnd (signed mode only):
- Quotient negated if the operand signs differ.
- Remainder negated if the dividend was negative.
REQ-018 DivByZero SHALL go to DivEnd next cycle with result 64'h0.
REQ-019 DivEnd SHALL drive ready_o=1 and hold result_o stable while start_i=1.
REQ-020 In DivEnd with start_i=0, the FSM SHALL return to DivFree next cycle, with ready_o=0 and result_o=0.
REQ-021 ready_o=0 and result_o=64'h0 SHALL hold in every state other than DivEnd.
REQ-022 Latency SHALL be measured from the first cycle with start_i=1 in DivFree, called cycle 0:
- ready_o=1 in cycle 33 for the normal path.
- ready_o=1 in cycle 2 for the divide-by-zero path.
REQ-023 annul_i=1 in DivOn or DivByZero SHALL force DivFree next cycle, discarding the result; ready_o SHALL never pulse.
REQ-024 annul_i=1 in DivEnd SHALL force DivFree next cycle; annul_i has priority over start_i.
REQ-025 Changes on opdata1_i, opdata2_i or signed_div_i after the latch SHALL NOT affect the result.
REQ-026 0x80000000 / 0xFFFFFFFF signed SHALL give quotient 0x80000000 (wrap) and remainder 0.

Reset
REQ-027 rst=1 on a rising edge SHALL force DivFree, clear the counter and working registers, and give ready_o=0 and result_o=0 from the next cycle, in any state including mid-DivOn.

Configuration
REQ-028 Macro DIV_BYZERO_EN defined: the DivByZero path of REQ-013/REQ-018 is compiled in.
REQ-029 Macro DIV_BYZERO_EN undefined: the DivByZero state SHALL NOT exist and a zero divisor runs the normal 32 steps.
- Unsigned: quotient 0xFFFFFFFF, remainder = dividend.
- Signed: the sign fix of REQ-017 applies.

Structure
REQ-030 State encodings (DivFree, DivByZero, DivOn, DivEnd), DivStart, DivStop, DivResultReady, DivResultNotReady, RegBus and DoubleRegBus SHALL live in the shared defines.v.
REQ-031 No sub-module: the 33-bit subtractor, negation logic and FSM SHALL be inline.

Verification
REQ-032 Unsigned 100 / 7: ready_o rises in cycle 33 with result_o = {32'd2, 32'd14}.
REQ-033 Signed -7 / 2: result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}.
REQ-034 Signed 0x80000000 / 0xFFFFFFFF: result_o = {32'h0, 32'h80000000}.
REQ-035 Unsigned 5 / 0:
- DIV_BYZERO_EN defined: result_o = 64'h0 with ready_o in cycle 2.
- DIV_BYZERO_EN undefined: result_o = {32'd5, 32'hFFFFFFFF} in cycle 33.
REQ-036 annul_i pulse in cycle 10:
- DivFree in cycle 11 and ready_o never rises.
- An immediate restart with 100 / 7 gives the REQ-032 result, with cycle 0 now being the restart cycle.
- rst=1 in cycle 20 likewise clears everything next cycle.
REQ-037 start_i held 5 cycles past ready: result stays stable; after start_i drops, ready_o=0 and result_o=0 one cycle later.
